// File: rtl/cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : cpu_datapath
// Purpose  : Register-and-bus datapath executing the per-cycle control word
//            from the control unit. It holds PC, AR, DR, IR, AC, R, R1-R4 and
//            the ALU result latch, and drives a single W-bit internal bus from
//            the source selected by read_en.
// Ports    : clk, rst_n            clock, async active-low reset
//            read_en[3:0]          bus source select
//            write_en/inc_en/clr_en[15:0]  load / increment / clear strobes
//            alu_op[2:0]           ALU function
//            im_rdata, dm_rdata    memory read data (combinational)
//            im_addr, dm_addr      PC / AR
//            dm_wdata, dm_we       bus value / write_en[11]
//            instruction[OPW-1:0]  IR opcode field
//            z[15:0]               {15'b0, AC==0}
//            bus_dbg               current bus value
// Revision : 1.0 - initial release
// ============================================================================
module cpu_datapath #(
  parameter int W   = 16,
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     read_en,
  input  logic [15:0]    write_en,
  input  logic [15:0]    inc_en,
  input  logic [15:0]    clr_en,
  input  logic [2:0]     alu_op,
  input  logic [W-1:0]   im_rdata,
  input  logic [W-1:0]   dm_rdata,
  output logic [W-1:0]   im_addr,
  output logic [W-1:0]   dm_addr,
  output logic [W-1:0]   dm_wdata,
  output logic           dm_we,
  output logic [OPW-1:0] instruction,
  output logic [15:0]    z,
  output logic [W-1:0]   bus_dbg
);

  localparam logic [W-1:0] C_ONE = W'(1);

  logic [W-1:0] pc_q, ar_q, dr_q, ir_q, ac_q, r_q;
  logic [W-1:0] r1_q, r2_q, r3_q, r4_q, alu_q;
  logic [W-1:0] pc_d, ar_d, dr_d, ir_d, ac_d, r_d;
  logic [W-1:0] r1_d, r2_d, r3_d, r4_d, alu_d;
  logic [W-1:0] bus_w;
  logic [W-1:0] alu_res_w;

  // ---------------------------------------------------------------- bus mux
  // Only the IR operand field is returned to the bus (jump / immediate use).
  always_comb begin
    bus_w = '0;
    case (read_en)
      4'd1:    bus_w = pc_q;
      4'd2:    bus_w = ar_q;
      4'd3:    bus_w = dr_q;
      4'd4:    bus_w = {{(W-10){1'b0}}, ir_q[9:0]};
      4'd5:    bus_w = ac_q;
      4'd6:    bus_w = r_q;
      4'd7:    bus_w = r1_q;
      4'd8:    bus_w = r2_q;
      4'd9:    bus_w = r3_q;
      4'd10:   bus_w = r4_q;
      4'd12:   bus_w = dm_rdata;
      4'd13:   bus_w = im_rdata;
      default: bus_w = '0;
    endcase
  end

  // -------------------------------------------------------------------- ALU
  always_comb begin
    alu_res_w = ac_q;
    case (alu_op)
      3'd1:    alu_res_w = ac_q + r_q;
      3'd2:    alu_res_w = ac_q - r_q;
      3'd3:    alu_res_w = ac_q * r_q;        // low W bits of product
      3'd4:    alu_res_w = {ac_q[W-2:0], 1'b0};
      default: alu_res_w = ac_q;
    endcase
  end

  // ------------------------------------------------------------ next state
  // Each register: clear > load > increment.
  always_comb begin
    pc_d  = pc_q;
    ar_d  = ar_q;
    dr_d  = dr_q;
    ir_d  = ir_q;
    ac_d  = ac_q;
    r_d   = r_q;
    r1_d  = r1_q;
    r2_d  = r2_q;
    r3_d  = r3_q;
    r4_d  = r4_q;
    alu_d = alu_q;

    if (clr_en[1])        pc_d = '0;
    else if (write_en[1]) pc_d = bus_w;
    else if (inc_en[1])   pc_d = pc_q + C_ONE;

    if (clr_en[2])        ar_d = '0;
    else if (write_en[2]) ar_d = bus_w;

    // DR has no load strobe: it shadows DM whenever DM drives the bus.
    if (clr_en[3])              dr_d = '0;
    else if (read_en == 4'd12)  dr_d = dm_rdata;

    if (write_en[3]) ir_d = bus_w;

    // AC selects the ALU latch ahead of a bus load; the latch value used is
    // the one held before this edge even if write_en[14] is also set.
    if (clr_en[4])         ac_d = '0;
    else if (write_en[12]) ac_d = alu_q;
    else if (write_en[4])  ac_d = bus_w;
    else if (inc_en[4])    ac_d = ac_q + C_ONE;

    if (clr_en[5])        r_d = '0;
    else if (write_en[5]) r_d = bus_w;

    if (write_en[10]) r1_d = bus_w;
    if (write_en[9])  r2_d = bus_w;
    if (write_en[8])  r3_d = bus_w;
    if (write_en[7])  r4_d = bus_w;

    if (write_en[14]) alu_d = alu_res_w;
  end

  // --------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      ar_q  <= '0;
      dr_q  <= '0;
      ir_q  <= '0;
      ac_q  <= '0;
      r_q   <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      r3_q  <= '0;
      r4_q  <= '0;
      alu_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ar_q  <= ar_d;
      dr_q  <= dr_d;
      ir_q  <= ir_d;
      ac_q  <= ac_d;
      r_q   <= r_d;
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      r3_q  <= r3_d;
      r4_q  <= r4_d;
      alu_q <= alu_d;
    end
  end

  // ----------------------------------------------------------------- outputs
  assign im_addr     = pc_q;
  assign dm_addr     = ar_q;
  assign dm_wdata    = bus_w;
  assign dm_we       = write_en[11];
  assign instruction = ir_q[W-1 -: OPW];
  assign z           = {15'b0, (ac_q == '0)};
  assign bus_dbg     = bus_w;

  // Strobe bits with no function in this datapath.
  logic unused_strobes;
  assign unused_strobes = ^{write_en[0], write_en[6], write_en[13], write_en[15],
                            inc_en[0], inc_en[3:2], inc_en[15:5],
                            clr_en[0], clr_en[15:6]};

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_datapath
// Purpose  : Directed table-driven bench for cpu_datapath plus hand-written
//            sequences for asynchronous reset and ALU-latch discard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_datapath;

  logic        clk;
  logic        rst_n;
  logic [3:0]  read_en;
  logic [15:0] write_en, inc_en, clr_en;
  logic [2:0]  alu_op;
  logic [15:0] im_rdata, dm_rdata;
  logic [15:0] im_addr, dm_addr, dm_wdata, bus_dbg, z;
  logic        dm_we;
  logic [5:0]  instruction;

  int errors = 0;
  int checks = 0;

  cpu_datapath #(.W(16), .OPW(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_en(read_en), .write_en(write_en), .inc_en(inc_en), .clr_en(clr_en),
    .alu_op(alu_op), .im_rdata(im_rdata), .dm_rdata(dm_rdata),
    .im_addr(im_addr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
    .instruction(instruction), .z(z), .bus_dbg(bus_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  re;
    logic [15:0] we, inc, clr;
    logic [2:0]  op;
    logic [15:0] im, dm;
    logic [15:0] bus;   // expected bus before the edge
    logic        dmwe;  // expected dm_we before the edge
    logic [15:0] pc;    // expected after the edge
    logic [15:0] ar;
    logic        zf;
    logic [5:0]  ins;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] re, input logic [15:0] we, input logic [15:0] inc,
                     input logic [15:0] clr, input logic [2:0] op, input logic [15:0] dm,
                     input logic [15:0] bus, input logic dmwe, input logic [15:0] pc,
                     input logic [15:0] ar, input logic zf);
    vec_t v;
    v.re = re; v.we = we; v.inc = inc; v.clr = clr; v.op = op;
    v.im = 16'h0C2A; v.dm = dm; v.bus = bus; v.dmwe = dmwe;
    v.pc = pc; v.ar = ar; v.zf = zf; v.ins = 6'd3;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    read_en = 4'd0; write_en = '0; inc_en = '0; clr_en = '0; alu_op = 3'd0;
    im_rdata = '0; dm_rdata = '0;
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    #1;
    // Reset state
    chk("rst im_addr", 32'(im_addr), 32'h0);
    chk("rst dm_addr", 32'(dm_addr), 32'h0);
    chk("rst instruction", 32'(instruction), 32'h0);
    chk("rst z", 32'(z), 32'h0001);
    chk("rst bus", 32'(bus_dbg), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------------------------------------- vector table
    // Fetch: IR <= im_rdata; then PC+1; then operand on bus; then jump.
    begin
      vec_t v;
      v.re = 4'd13; v.we = 16'h0008; v.inc = '0; v.clr = '0; v.op = 3'd0;
      v.im = 16'h0C2A; v.dm = '0; v.bus = 16'h0C2A; v.dmwe = 1'b0;
      v.pc = 16'h0; v.ar = 16'h0; v.zf = 1'b1; v.ins = 6'd3;
      vecs.push_back(v);
    end
    //   re     we        inc       clr       op  dm        bus       we  pc        ar        z
    add(4'd0,  16'h0000, 16'h0002, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0001, 16'h0000, 1);
    add(4'd4,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h002A, 0, 16'h0001, 16'h0000, 1);
    add(4'd4,  16'h0002, 16'h0000, 16'h0000, 0, 16'h0000, 16'h002A, 0, 16'h002A, 16'h0000, 1);
    // Add: AC=5, R=7
    add(4'd12, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0005, 16'h0005, 0, 16'h002A, 16'h0000, 0);
    add(4'd12, 16'h0020, 16'h0000, 16'h0000, 0, 16'h0007, 16'h0007, 0, 16'h002A, 16'h0000, 0);
    add(4'd0,  16'h4000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0, 16'h002A, 16'h0000, 0);
    add(4'd0,  16'h1000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h002A, 16'h0000, 0);
    add(4'd5,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h000C, 0, 16'h002A, 16'h0000, 0);
    // Sub: 5-7
    add(4'd12, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0005, 16'h0005, 0, 16'h002A, 16'h0000, 0);
    add(4'd0,  16'h4000, 16'h0000, 16'h0000, 2, 16'h0000, 16'h0000, 0, 16'h002A, 16'h0000, 0);
    add(4'd0,  16'h1000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h002A, 16'h0000, 0);
    add(4'd5,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'hFFFE, 0, 16'h002A, 16'h0000, 0);
    // Mult: AC=R=0x0100 loaded together, product low bits = 0
    add(4'd12, 16'h0030, 16'h0000, 16'h0000, 0, 16'h0100, 16'h0100, 0, 16'h002A, 16'h0000, 0);
    add(4'd0,  16'h4000, 16'h0000, 16'h0000, 3, 16'h0000, 16'h0000, 0, 16'h002A, 16'h0000, 0);
    add(4'd0,  16'h1000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h002A, 16'h0000, 1);
    // Shift: 0x8001 << 1 = 0x0002
    add(4'd12, 16'h0010, 16'h0000, 16'h0000, 0, 16'h8001, 16'h8001, 0, 16'h002A, 16'h0000, 0);
    add(4'd0,  16'h4000, 16'h0000, 16'h0000, 4, 16'h0000, 16'h0000, 0, 16'h002A, 16'h0000, 0);
    add(4'd0,  16'h1000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h002A, 16'h0000, 0);
    add(4'd5,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0002, 0, 16'h002A, 16'h0000, 0);
    // write_en[14] and [12] together: AC gets old latch (2), latch <= 5+0x100
    add(4'd12, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0005, 16'h0005, 0, 16'h002A, 16'h0000, 0);
    add(4'd0,  16'h5000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0, 16'h002A, 16'h0000, 0);
    add(4'd5,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0002, 0, 16'h002A, 16'h0000, 0);
    add(4'd0,  16'h1000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h002A, 16'h0000, 0);
    add(4'd5,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0105, 0, 16'h002A, 16'h0000, 0);
    // Store / load
    add(4'd12, 16'h0010, 16'h0000, 16'h0000, 0, 16'h00A5, 16'h00A5, 0, 16'h002A, 16'h0000, 0);
    add(4'd5,  16'h0004, 16'h0000, 16'h0000, 0, 16'h0000, 16'h00A5, 0, 16'h002A, 16'h00A5, 0);
    add(4'd5,  16'h0800, 16'h0000, 16'h0000, 0, 16'h0000, 16'h00A5, 1, 16'h002A, 16'h00A5, 0);
    add(4'd12, 16'h0010, 16'h0000, 16'h0000, 0, 16'h3C3C, 16'h3C3C, 0, 16'h002A, 16'h00A5, 0);
    add(4'd3,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h3C3C, 0, 16'h002A, 16'h00A5, 0);
    add(4'd5,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h3C3C, 0, 16'h002A, 16'h00A5, 0);
    // Priority
    add(4'd12, 16'h0010, 16'h0010, 16'h0010, 0, 16'h1234, 16'h1234, 0, 16'h002A, 16'h00A5, 1);
    add(4'd12, 16'h0002, 16'h0002, 16'h0000, 0, 16'h0040, 16'h0040, 0, 16'h0040, 16'h00A5, 1);
    add(4'd12, 16'h0010, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'hFFFF, 0, 16'h0040, 16'h00A5, 0);
    add(4'd0,  16'h0000, 16'h0010, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0040, 16'h00A5, 1);
    // R1..R4
    add(4'd12, 16'h0400, 16'h0000, 16'h0000, 0, 16'h1111, 16'h1111, 0, 16'h0040, 16'h00A5, 1);
    add(4'd12, 16'h0200, 16'h0000, 16'h0000, 0, 16'h2222, 16'h2222, 0, 16'h0040, 16'h00A5, 1);
    add(4'd12, 16'h0100, 16'h0000, 16'h0000, 0, 16'h3333, 16'h3333, 0, 16'h0040, 16'h00A5, 1);
    add(4'd12, 16'h0080, 16'h0000, 16'h0000, 0, 16'h4444, 16'h4444, 0, 16'h0040, 16'h00A5, 1);
    add(4'd7,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h1111, 0, 16'h0040, 16'h00A5, 1);
    add(4'd8,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h2222, 0, 16'h0040, 16'h00A5, 1);
    add(4'd9,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h3333, 0, 16'h0040, 16'h00A5, 1);
    add(4'd10, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h4444, 0, 16'h0040, 16'h00A5, 1);
    // Reserved sources drive 0
    add(4'd11, 16'h0000, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0000, 0, 16'h0040, 16'h00A5, 1);
    add(4'd14, 16'h0000, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0000, 0, 16'h0040, 16'h00A5, 1);
    // PC wrap, clears, clear-over-load
    add(4'd12, 16'h0002, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'hFFFF, 0, 16'hFFFF, 16'h00A5, 1);
    add(4'd0,  16'h0000, 16'h0002, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h00A5, 1);
    add(4'd12, 16'h0006, 16'h0000, 16'h0000, 0, 16'h0055, 16'h0055, 0, 16'h0055, 16'h0055, 1);
    add(4'd0,  16'h0000, 16'h0000, 16'h003E, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1);
    add(4'd6,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1);
    add(4'd3,  16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1);
    add(4'd12, 16'h0002, 16'h0000, 16'h0002, 0, 16'h0077, 16'h0077, 0, 16'h0000, 16'h0000, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      read_en = vecs[i].re; write_en = vecs[i].we; inc_en = vecs[i].inc;
      clr_en = vecs[i].clr; alu_op = vecs[i].op;
      im_rdata = vecs[i].im; dm_rdata = vecs[i].dm;
      #1;
      chk($sformatf("v%0d bus", i), 32'(bus_dbg), 32'(vecs[i].bus));
      chk($sformatf("v%0d dm_wdata", i), 32'(dm_wdata), 32'(vecs[i].bus));
      chk($sformatf("v%0d dm_we", i), 32'(dm_we), 32'(vecs[i].dmwe));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc", i), 32'(im_addr), 32'(vecs[i].pc));
      chk($sformatf("v%0d ar", i), 32'(dm_addr), 32'(vecs[i].ar));
      chk($sformatf("v%0d z", i), 32'(z), {31'b0, vecs[i].zf});
      chk($sformatf("v%0d instr", i), 32'(instruction), 32'(vecs[i].ins));
    end

    // ---------------------------------------------- async reset mid-run
    @(negedge clk); drive_idle(); read_en = 4'd12; dm_rdata = 16'h0007; write_en = 16'h0002;
    @(negedge clk); dm_rdata = 16'h1234; write_en = 16'h0010;
    @(negedge clk); read_en = 4'd0; dm_rdata = '0; write_en = 16'h4000; alu_op = 3'd1;
    @(negedge clk);
    read_en = 4'd5; write_en = 16'h0800; alu_op = 3'd0;
    #1;
    chk("pre-rst pc", 32'(im_addr), 32'h0007);
    chk("pre-rst ac", 32'(bus_dbg), 32'h1234);
    chk("pre-rst z", 32'(z), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst pc", 32'(im_addr), 32'h0);
    chk("async rst ac", 32'(bus_dbg), 32'h0);
    chk("async rst z", 32'(z), 32'h0001);
    chk("rst dm_we ungated", 32'(dm_we), 32'h1);
    @(negedge clk);
    // ALU latch must have been discarded by reset
    rst_n = 1'b1; write_en = 16'h1000; read_en = 4'd0;
    @(posedge clk); #1;
    chk("latch discarded z", 32'(z), 32'h0001);
    @(negedge clk); write_en = '0; read_en = 4'd5;
    #1;
    chk("latch discarded ac", 32'(bus_dbg), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_datapath.md
# cpu_datapath

Register-and-bus datapath that executes the per-cycle control word issued by the processor control unit. It holds PC, AR, DR, IR, AC, R, R1–R4 and the ALU result latch, and drives a single 16-bit internal bus from the source named by `read_en`. It loads destinations named by `write_en`/`inc_en`/`clr_en` and returns the opcode and zero flag to the controller. It is the responder side of the control-word interface and sits between the control unit and the instruction/data memories.

## Interface
- `W`, 16, datapath/bus width; all registers are W bits.
- `OPW`, 6, opcode width returned to control.
- `clk` input 1: datapath clock. All registers update on the rising edge. The control unit changes state on the falling edge, so control inputs are stable around `posedge clk`.
- `rst_n` input 1: reset, asynchronous, active-low.
- `read_en` input 4: bus source select.
- `write_en` input 16: load strobes.
- `inc_en` input 16: increment strobes.
- `clr_en` input 16: clear strobes.
- `alu_op` input 3: ALU function.
- `im_rdata` input W: instruction memory read data, combinational from `im_addr`.
- `dm_rdata` input W: data memory read data, combinational from `dm_addr`.
- `im_addr` output W: equals PC.
- `dm_addr` output W: equals AR.
- `dm_wdata` output W: equals the bus.
- `dm_we` output 1: equals `write_en[11]`; DM captures on the same `posedge clk`.
- `instruction` output OPW: IR[15:10].
- `z` output 16: {15'b0, AC==0}.
- `bus_dbg` output W: current bus value.

## Operation
- Bus source by `read_en`:
  - 0: 0
  - 1: PC
  - 2: AR
  - 3: DR
  - 4: {6'b0, IR[9:0]}
  - 5: AC
  - 6: R
  - 7–10: R1–R4
  - 12: `dm_rdata`
  - 13: `im_rdata`
  - 11, 14, 15: 0 (reserved)
- IR load takes the full bus value. Only the operand field IR[9:0] is driven back onto the bus.
- Strobe bit map:
  - `write_en` bus loads: 1 PC, 2 AR, 3 IR, 4 AC, 5 R, 7 R4, 8 R3, 9 R2, 10 R1.
  - `write_en` special: 11 DM write; 12 AC <= ALU latch; 14 ALU latch <= f(AC,R).
  - `write_en` bits 0, 6, 13, 15: ignored.
  - `inc_en`: 1 PC, 4 AC.
  - `clr_en`: 1 PC, 2 AR, 3 DR, 4 AC, 5 R. Other bits ignored.
- Per-register priority is clear > load > increment.
- AC priority is `clr_en[4]` > `write_en[12]` > `write_en[4]` > `inc_en[4]`.
- Any number of destinations may load from the bus in one cycle. Each takes the same bus value.
- DR has no bus load bit. It loads `dm_rdata` whenever `read_en==12`, which gives a DM shadow for debug and DR reads.
- ALU (on `write_en[14]`), result taken mod 2^W:
  - 0: AC
  - 1: AC+R
  - 2: AC−R (two's-complement wrap)
  - 3: low W bits of AC*R
  - 4: AC<<1 (LSB 0)
  - 5–7: AC
- Flags: `z[0]` is combinational from the AC register, so it reflects the value after the latest edge.

## Timing
- Reset (async assert, release sampled at the next `posedge`): every register is 0.
  - `im_addr`=0, `dm_addr`=0, `instruction`=0, `z`=16'h0001.
  - `dm_we` follows `write_en[11]` combinationally and is not gated by reset.
- Reset asserted mid-operation clears all registers immediately. An in-flight ALU latch value is discarded.
- Register latency: a load, increment or clear issued in cycle n is visible at outputs after `posedge` n.
- Two-cycle ALU: the cycle with `write_en[14]` latches the result. A later cycle with `write_en[12]` moves it to AC. If both are set in one cycle, AC takes the old latch value.
- Fetch: cycle with `read_en=13`, `write_en[3]` sets IR=`im_rdata`@PC. A cycle with `inc_en[1]` gives PC+1, wrapping FFFF→0000.
- Jump: `read_en=4`, `write_en[1]` sets PC={6'b0,IR[9:0]}.
- Load/store: AR is loaded in one cycle. A DM read the following cycle returns data for the new AR. On DM write, `dm_wdata` equals the bus in the same cycle.
- AC increment wraps FFFF→0000 and sets `z`.

## Test plan
- Reset: drive `rst_n`=0 mid-run with PC=0x0007, AC=0x1234 → PC=0, AC=0, `z`=1 immediately, before any clock edge.
- Fetch: `im_rdata`=0x0C2A at PC 0, then fetch1/fetch2 words → IR=0x0C2A, `instruction`=6'd3, PC=1; `read_en=4` then drives bus=0x002A.
- Add/sub: AC=5, R=7.
  - Add: `write_en[14]`, `alu_op`=1, then `write_en[12]` → AC=0x000C.
  - Sub: repeat with `alu_op`=2 → AC=0xFFFE, `z`=0.
- Mult and shift: AC=0x0100, R=0x0100, `alu_op`=3 → AC=0x0000, `z`=1. Then AC=0x8001, `alu_op`=4 → AC=0x0002.
- Store/load: AC=0x00A5.
  - Store: `read_en=5`, `write_en[2]` → AR=0x00A5. Then `read_en=5`, `write_en[11]` → `dm_we`=1, `dm_addr`=0x00A5, `dm_wdata`=0x00A5.
  - Load: `read_en=12` with `dm_rdata`=0x3C3C, `write_en[4]` → AC=0x3C3C, DR=0x3C3C.
- Priority: same cycle `clr_en[4]`, `write_en[4]`, `inc_en[4]` → AC=0. Same cycle `write_en[1]` (bus=0x0040) and `inc_en[1]` → PC=0x0040. AC=0xFFFF with `inc_en[4]` → AC=0, `z`=1.
